// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and defaults for the chained-element FIFO.
// Rev 1.0
`default_nettype none

package fifo_pkg;

  localparam int FIFO_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_SETTLE  = 2'd2,
    S_FLUSH   = 2'd3
  } fifo_reader_state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_parity_gen.sv
// fifo_parity_gen: combinational odd parity over WIDTH bits (1 when the bit count is even).
// Rev 1.0
`default_nettype none

module fifo_parity_gen
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ~^data;

endmodule

`default_nettype wire

// File: rtl/fifo_reader.sv
// fifo_reader: pops the FIFO head onto a valid/ack port, with flush and delivered-word count.
// Optional rd_parity output under FIFO_READER_PARITY_EN. Rev 1.0
`default_nettype none

module fifo_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_DEFAULT_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 head_used,
  input  logic [WIDTH-1:0]     head_q,
  output logic                 head_strobe,
  input  logic                 flush,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ack,
  output logic [CNT_WIDTH-1:0] rd_count
`ifdef FIFO_READER_PARITY_EN
  ,
  output logic                 rd_parity
`endif
);

  fifo_reader_state_t state;

`ifdef FIFO_READER_PARITY_EN
  logic head_parity;

  fifo_parity_gen #(
    .WIDTH (WIDTH)
  ) u_parity (
    .data   (head_q),
    .parity (head_parity)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      head_strobe <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_count    <= '0;
`ifdef FIFO_READER_PARITY_EN
      rd_parity   <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          head_strobe <= 1'b0;
          if (flush) begin
            state <= S_FLUSH;
          end else if (head_used) begin
            rd_data     <= head_q;
`ifdef FIFO_READER_PARITY_EN
            rd_parity   <= head_parity;
`endif
            rd_valid    <= 1'b1;
            head_strobe <= 1'b1;
            state       <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          head_strobe <= 1'b0;
          // flush beats a simultaneous ack: the word is dropped uncounted
          if (flush) begin
            rd_valid <= 1'b0;
            state    <= S_FLUSH;
          end else if (rd_ack) begin
            rd_valid <= 1'b0;
            rd_count <= rd_count + 1'b1;
            state    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          head_strobe <= 1'b0;
          state       <= S_IDLE;
        end
        S_FLUSH: begin
          // strobe/settle alternation lets head_used catch up after each pop
          head_strobe <= !head_strobe && head_used && flush;
          if (!head_strobe && (!flush || !head_used))
            state <= S_IDLE;
        end
        default: begin
          head_strobe <= 1'b0;
          rd_valid    <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed self-checking bench for fifo_reader with a small FIFO-chain model.
// Rev 1.0
`default_nettype none

module tb_fifo_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        rd_ack = 1'b0;
  logic        head_used;
  logic [7:0]  head_q;
  logic        head_strobe;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [15:0] rd_count;
`ifdef FIFO_READER_PARITY_EN
  logic        rd_parity;
`endif

  int vectors = 0;
  int errors  = 0;

  // chain model: head element is mem[rd_ptr], popped on each strobed edge
  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int strobes = 0;
  int dbl = 0;
  logic prev_strobe = 1'b0;
  int s0;

  assign head_used = (wr_ptr != rd_ptr);
  assign head_q    = mem[rd_ptr % 16];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (head_strobe) begin
      rd_ptr  <= rd_ptr + 1;
      strobes <= strobes + 1;
    end
    if (head_strobe && prev_strobe) dbl <= dbl + 1;
    prev_strobe <= head_strobe;
  end

  fifo_reader #(
    .WIDTH     (8),
    .CNT_WIDTH (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .head_used   (head_used),
    .head_q      (head_q),
    .head_strobe (head_strobe),
    .flush       (flush),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ack      (rd_ack),
    .rd_count    (rd_count)
`ifdef FIFO_READER_PARITY_EN
    ,
    .rd_parity   (rd_parity)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr % 16] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // reset state
    cyc(); cyc();
    chk("rst_valid", rd_valid, 0);
    chk("rst_strobe", head_strobe, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_count", rd_count, 0);
`ifdef FIFO_READER_PARITY_EN
    chk("rst_parity", rd_parity, 1);
`endif
    reset_n = 1'b1;
    cyc();

    // single word, ack two cycles after valid
    s0 = strobes;
    push(8'hAA);
    cyc();
    chk("single_valid", rd_valid, 1);
    chk("single_data", rd_data, 8'hAA);
    chk("single_strobe_hi", head_strobe, 1);
    cyc();
    chk("single_strobe_lo", head_strobe, 0);
    chk("single_hold", rd_valid, 1);
    rd_ack = 1'b1;
    cyc();
    chk("single_valid_lo", rd_valid, 0);
    chk("single_count", rd_count, 1);
    rd_ack = 1'b0;
    cyc();
    chk("single_strobes", strobes - s0, 1);
    chk("single_empty", head_used, 0);

    // back-to-back with ack tied high: one word every third cycle
    rd_ack = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    cyc();
    chk("b2b_valid0", rd_valid, 1); chk("b2b_data0", rd_data, 8'h11);
    cyc(); chk("b2b_gap0a", rd_valid, 0);
    cyc(); chk("b2b_gap0b", rd_valid, 0);
    cyc();
    chk("b2b_valid1", rd_valid, 1); chk("b2b_data1", rd_data, 8'h22);
    cyc(); chk("b2b_gap1a", rd_valid, 0);
    cyc(); chk("b2b_gap1b", rd_valid, 0);
    cyc();
    chk("b2b_valid2", rd_valid, 1); chk("b2b_data2", rd_data, 8'h33);
    cyc(); chk("b2b_gap2a", rd_valid, 0);
    cyc(); chk("b2b_gap2b", rd_valid, 0);
    chk("b2b_count", rd_count, 4);
    rd_ack = 1'b0;

    // stall: ack withheld for ten cycles
    s0 = strobes;
    push(8'h55);
    cyc();
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", rd_valid, 1);
      chk("stall_data", rd_data, 8'h55);
      cyc();
    end
    chk("stall_strobes", strobes - s0, 1);
    chk("stall_count", rd_count, 4);
    rd_ack = 1'b1;
    cyc();
    chk("stall_ack_valid", rd_valid, 0);
    chk("stall_ack_count", rd_count, 5);
    rd_ack = 1'b0;
    cyc();

    // flush with simultaneous ack during PRESENT
    s0 = strobes;
    push(8'h61); push(8'h62); push(8'h63); push(8'h64);
    cyc();
    chk("flush_pres_valid", rd_valid, 1);
    flush = 1'b1;
    rd_ack = 1'b1;
    cyc();
    chk("flush_drop_valid", rd_valid, 0);
    chk("flush_drop_count", rd_count, 5);
    chk("flush_strobe_f1", head_strobe, 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("flush_strobe_pat", head_strobe, (i % 2 == 0) ? 1 : 0);
      chk("flush_valid", rd_valid, 0);
    end
    chk("flush_drained", head_used, 0);
    chk("flush_strobes", strobes - s0, 4);
    chk("flush_count", rd_count, 5);
    flush = 1'b0;
    rd_ack = 1'b0;
    cyc();

    // back in IDLE: a new word is presented, then reset lands mid-PRESENT
    push(8'h77);
    cyc();
    chk("post_flush_valid", rd_valid, 1);
    chk("post_flush_data", rd_data, 8'h77);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", rd_valid, 0);
    chk("arst_strobe", head_strobe, 0);
    chk("arst_data", rd_data, 0);
    chk("arst_count", rd_count, 0);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("rerun_valid", rd_valid, 1);
    chk("rerun_data", rd_data, 8'h77);
`ifdef FIFO_READER_PARITY_EN
    chk("rerun_parity", rd_parity, 1);
`endif
    rd_ack = 1'b1;
    cyc();
    chk("rerun_count", rd_count, 1);
    cyc();
    rd_ack = 1'b0;

`ifdef FIFO_READER_PARITY_EN
    rd_ack = 1'b1;
    push(8'h01); push(8'h03);
    cyc();
    chk("par01_data", rd_data, 8'h01);
    chk("par01_parity", rd_parity, 0);
    cyc(); cyc(); cyc();
    chk("par03_data", rd_data, 8'h03);
    chk("par03_parity", rd_parity, 1);
    cyc(); cyc();
    chk("par_count", rd_count, 3);
    rd_ack = 1'b0;
`endif

    chk("no_double_strobe", dbl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_reader.md
# fifo_reader

Read-side controller at the output end of the chained-element FIFO. It watches the head element's `used` flag, latches the head data, and pulses the element's output strobe so the chain shifts forward. It presents each byte to the downstream consumer on a valid/ack handshake. It also supports a flush that drains the chain without delivering data, and keeps a count of delivered words.

## Interface
Parameters:
- `WIDTH`, 8, data width; must match the FIFO elements.
- `CNT_WIDTH`, 16, width of the delivered-word counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `head_used`  in  1  `used` flag of the last FIFO element (data available).
- `head_q`  in  WIDTH  `q` of the last FIFO element.
- `head_strobe`  out  1  drives `q_out_strobe` of the last element; one-cycle pulse pops the head.
- `flush`  in  1  level; while high, the chain is drained and data is discarded.
- `rd_data`  out  WIDTH  word presented to the consumer.
- `rd_valid`  out  1  `rd_data` is valid.
- `rd_ack`  in  1  consumer accepts `rd_data`; sampled only while `rd_valid`=1.
- `rd_count`  out  CNT_WIDTH  words delivered (acked) since reset; wraps.
- `rd_parity`  out  1  odd parity of `rd_data`. Present only with `FIFO_READER_PARITY_EN`.

## Operation
States: IDLE, PRESENT, SETTLE, FLUSH.
- **IDLE**
  - `flush`=1 → FLUSH. Flush has priority over `head_used`.
  - Else `head_used`=1 → `rd_data`<=`head_q`, `rd_valid`<=1, `head_strobe`<=1, go to PRESENT.
  - Else stay in IDLE.
- **PRESENT**
  - `head_strobe`<=0 on the first edge, so the pulse is exactly one cycle.
  - `flush`=1 → `rd_valid`<=0, no count, go to FLUSH.
  - Else `rd_ack`=1 → `rd_valid`<=0, `rd_count`<=`rd_count`+1 (mod 2^CNT_WIDTH), go to SETTLE.
  - Else hold `rd_data` and `rd_valid` stable.
- **SETTLE**
  - One cycle, so `head_used` reflects the shifted chain.
  - Always → IDLE.
- **FLUSH**
  - Alternates strobe and settle cycles.
  - If `head_strobe`=0, `head_used`=1 and `flush`=1 → `head_strobe`<=1.
  - Otherwise `head_strobe`<=0.
  - Exit to IDLE on an edge where `head_strobe`=0 and either `flush`=0 or `head_used`=0.
  - `rd_valid` stays 0 and `rd_count` is unchanged throughout.

Rules:
- `rd_ack` while `rd_valid`=0 is ignored.
- `flush` and `rd_ack` in the same PRESENT cycle: flush wins; the word is discarded and not counted.
- `head_strobe` is never high in two consecutive cycles.
- `head_q` is sampled only on the edge that raises `head_strobe`.
- Reset values:
  - state=IDLE
  - `head_strobe`=0
  - `rd_valid`=0
  - `rd_data`=0
  - `rd_count`=0
  - `rd_parity`=1 (odd parity of zero)
- Reset mid-transfer:
  - Outputs clear immediately (asynchronously).
  - A pending word is lost from the reader.
  - FIFO elements are not reset by this block.

## Timing
- `head_used` high at edge N (IDLE) → `rd_valid`, `rd_data` and `head_strobe` high after edge N.
- The element shifts at edge N+1.
- Ack sampled at edge M → `rd_valid` low after M; SETTLE during M..M+1; IDLE from M+1.
- Next `rd_valid` no earlier than after edge M+2.
- Maximum throughput: one word per 3 cycles with `rd_ack` tied high.
- Flush rate: one element per 2 cycles.

## Configuration
- `FIFO_READER_PARITY_EN` defined:
  - `rd_parity` port exists.
  - Registered together with `rd_data`, with equal timing.
  - Value is ~^`rd_data`.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `fifo_pkg`:
  - state encoding typedef `fifo_reader_state_t` (IDLE=0, PRESENT=1, SETTLE=2, FLUSH=3)
  - `FIFO_DEFAULT_WIDTH`=8
- One sub-module, `fifo_parity_gen`: combinational odd-parity of WIDTH bits, instantiated only under the macro.
- FSM, counter and output registers sit in `fifo_reader` itself.

## Test plan
- **Single word:** `head_used`=1, `head_q`=AA, ack 2 cycles after valid → `rd_data`=AA; exactly one `head_strobe` pulse; `rd_count`=1; `rd_valid` low after ack edge.
- **Back-to-back:** 3 elements 11,22,33, `rd_ack` tied 1 → `rd_data` sequence 11,22,33, each valid for 1 cycle, 3-cycle spacing; `rd_count`=3.
- **Stall:** `head_q`=55, `rd_ack` withheld 10 cycles → `rd_data`=55 and `rd_valid`=1 stable; no further strobes; `rd_count` unchanged.
- **Flush:**
  - 4 elements, `flush`=1 during PRESENT with `rd_ack`=1 → discarded, `rd_count` unchanged, 3 further strobes spaced 2 cycles.
  - IDLE once `head_used`=0.
- **Reset mid-operation:** `reset_n` low while PRESENT → `rd_valid`, `head_strobe`, `rd_data` and `rd_count` go 0 without a clock edge; after release, IDLE.
- **Parity (macro on):** `head_q`=01 → `rd_parity`=0; `head_q`=03 → `rd_parity`=1; reset value 1.
